seq_pattern_detector: RTL

//  Runtime-programmable serial pattern detector. Generalised successor of the fixed "110" Moore detector.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/sat_counter.sv | 35 +++
 rtl/seq_pattern_detector.sv | 100 ++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the serial pattern detector.
// The reset values reproduce the legacy fixed "110" overlapping detector.
package seq_det_pkg;

    localparam logic [2:0] DEF_PATTERN = 3'b110;
    localparam int         DEF_LEN     = 3;
    localparam logic       DEF_OVERLAP = 1'b1;

    // A zero length would never match, so it is treated as length 1.
    function automatic int clamp_len(input int len, input int max_len);
        if (len < 1) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear wins over a simultaneous increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlapping/non-overlapping
// modes, a registered one-cycle match pulse and a saturating match count.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               x,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   cur_len
);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               z_q, z_d;

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] new_hist;
    logic               primed;
    logic               match;

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        new_hist = {hist_q[MAX_LEN-2:0], x};
        // Primed once the incoming sample can complete a full pattern.
        primed   = int'(fill_q) >= (int'(len_q) - 1);
        match    = !cfg_we && in_valid && primed
                   && (((new_hist ^ pattern_q) & mask) == '0);
    end

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        z_d       = 1'b0;
        if (cfg_we) begin
            pattern_d = cfg_pattern;
            len_d     = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            hist_d = new_hist;
            z_d    = match;
            if (match && !overlap_q) begin
                fill_d = '0;
            end else if (fill_q != len_q) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= MAX_LEN'(DEF_PATTERN);
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            z_q       <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            z_q       <= z_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .inc   (match),
        .clr   (cnt_clr),
        .q     (match_count)
    );

    assign z       = z_q;
    assign cur_len = len_q;

endmodule
